// File: rtl/statelogic_pkg.sv
// Shared controller definitions: state encodings and opcode constants.
// The output decoder imports this package too, so the encodings stay in step.
package statelogic_pkg;

  // Encodings are fixed because the output decoder depends on them.
  typedef enum logic [3:0] {
    FETCH1  = 4'd0,
    FETCH2  = 4'd1,
    FETCH3  = 4'd2,
    FETCH4  = 4'd3,
    DECODE  = 4'd4,
    MEMADR  = 4'd5,
    LBRD    = 4'd6,
    LBWR    = 4'd7,
    SBWR    = 4'd8,
    RTYPEEX = 4'd9,
    RTYPEWR = 4'd10,
    BEQEX   = 4'd11,
    JEX     = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;

endpackage

// File: rtl/retire_counter.sv
// Retired-instruction counter; wraps modulo 2^CNTW, synchronous reset wins over inc.
module retire_counter #(
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inc,
  output logic [CNTW-1:0] count
);

  logic [CNTW-1:0] count_q;
  logic [CNTW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc) begin
      count_d = count_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/statelogic.sv
// Multicycle controller state register and next-state logic, with the
// illegal-opcode pulse and the retired-instruction counter.
//
// state   | meaning
// FETCH1  | fetch cycle 1; first cycle of every instruction
// FETCH2  | fetch cycle 2
// FETCH3  | fetch cycle 3
// FETCH4  | fetch cycle 4
// DECODE  | decode live op, latch it
// MEMADR  | memory address calc; branch on latched op
// LBRD    | load byte read
// LBWR    | load byte writeback, retires
// SBWR    | store byte write, retires
// RTYPEEX | R-type execute
// RTYPEWR | R-type writeback, retires
// BEQEX   | branch execute, retires
// JEX     | jump execute, retires
// 13..15  | unused, recover to FETCH1 silently
module statelogic
  import statelogic_pkg::*;
#(
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [5:0]      op,
  output logic [3:0]      state,
  output logic            illegal,
  output logic [CNTW-1:0] instret
);

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic [5:0] op_q;
  logic [5:0] op_d;
  logic       illegal_q;
  logic       illegal_d;
  logic       retire;

  always_comb begin
    state_d   = FETCH1;
    op_d      = op_q;
    illegal_d = 1'b0;
    retire    = 1'b0;
    case (state_q)
      FETCH1:  state_d = FETCH2;
      FETCH2:  state_d = FETCH3;
      FETCH3:  state_d = FETCH4;
      FETCH4:  state_d = DECODE;
      DECODE: begin
        op_d = op;
        case (op)
          OP_LB, OP_SB: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_J:         state_d = JEX;
          default: begin
            state_d   = FETCH1;
            illegal_d = 1'b1;
          end
        endcase
      end
      // Only LB or SB can reach MEMADR, so the latched op always matches one arm.
      MEMADR: begin
        if (op_q == OP_SB) begin
          state_d = SBWR;
        end else begin
          state_d = LBRD;
        end
      end
      LBRD:    state_d = LBWR;
      LBWR:    retire  = 1'b1;
      SBWR:    retire  = 1'b1;
      RTYPEEX: state_d = RTYPEWR;
      RTYPEWR: retire  = 1'b1;
      BEQEX:   retire  = 1'b1;
      JEX:     retire  = 1'b1;
      default: state_d = FETCH1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH1;
      op_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
    end
  end

  retire_counter #(
    .CNTW(CNTW)
  ) u_retire_counter (
    .clk  (clk),
    .reset(reset),
    .inc  (retire),
    .count(instret)
  );

  assign state   = state_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_statelogic.sv
// Scoreboard bench for statelogic: a driver issues random instructions and pushes
// the expected per-cycle outputs; a negedge monitor pops and compares.
module tb_statelogic;

  localparam int CNTW = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [5:0]      op = 6'd0;
  logic [3:0]      state;
  logic            illegal;
  logic [CNTW-1:0] instret;

  always #5 clk = ~clk;

  statelogic #(.CNTW(CNTW)) dut (
    .clk    (clk),
    .reset  (reset),
    .op     (op),
    .state  (state),
    .illegal(illegal),
    .instret(instret)
  );

  typedef struct packed {
    logic [3:0]      st;
    logic            ill;
    logic [CNTW-1:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // reference model state: retired count and pending illegal flag for next FETCH1
  int   m_cnt = 0;
  bit   m_ill = 1'b0;

  // instruction kinds: 0 LB, 1 SB, 2 RTYPE, 3 BEQ, 4 J, 5 illegal
  function automatic int instr_len(input int kind);
    case (kind)
      0:       return 8;
      1:       return 7;
      2:       return 7;
      3:       return 6;
      4:       return 6;
      default: return 5;
    endcase
  endfunction

  function automatic logic [5:0] kind_op(input int kind);
    logic [5:0] o;
    case (kind)
      0: o = 6'b100000;
      1: o = 6'b101000;
      2: o = 6'b000000;
      3: o = 6'b000100;
      4: o = 6'b000010;
      default: begin
        do o = 6'($urandom_range(0, 63));
        while (o == 6'b100000 || o == 6'b101000 || o == 6'b000000 ||
               o == 6'b000100 || o == 6'b000010);
      end
    endcase
    return o;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      vectors++;
      if (state !== e.st || illegal !== e.ill || instret !== e.cnt) begin
        miscompares++;
        $display("FAIL cycle_check t=%0t: got state=%0d illegal=%b instret=%0d, expected state=%0d illegal=%b instret=%0d",
                 $time, state, illegal, instret, e.st, e.ill, e.cnt);
      end
    end
  end

  task automatic push_exp(input int st, input bit ill, input int cnt);
    exp_t e;
    e.st  = 4'(st);
    e.ill = ill;
    e.cnt = CNTW'(cnt);
    sb_q.push_back(e);
  endtask

  // abort_at: cycle index within the instruction at which reset is raised (-1 = none)
  task automatic run_instr(input int kind, input int abort_at, input logic [5:0] force_op);
    int         p[$];
    logic [5:0] opc;
    p = '{0, 1, 2, 3, 4};
    case (kind)
      0: begin p.push_back(5); p.push_back(6); p.push_back(7); end
      1: begin p.push_back(5); p.push_back(8); end
      2: begin p.push_back(9); p.push_back(10); end
      3: p.push_back(11);
      4: p.push_back(12);
      default: ;
    endcase
    opc = (kind == 5 && force_op != 6'd0) ? force_op : kind_op(kind);
    for (int k = 0; k < p.size(); k++) begin
      @(posedge clk);
      #1;
      reset = (k == abort_at);
      op = (k == 4) ? opc : 6'($urandom_range(0, 63));
      push_exp(p[k], (k == 0) ? m_ill : 1'b0, m_cnt);
      if (k == abort_at) begin
        m_cnt = 0;
        m_ill = 1'b0;
        return;
      end
    end
    if (kind == 5) begin
      m_ill = 1'b1;
    end else begin
      m_ill = 1'b0;
      m_cnt = (m_cnt + 1) % (1 << CNTW);
    end
  endtask

  initial begin
    int kind;
    int ab;
    reset = 1'b1;
    op = 6'b000000;
    repeat (3) begin
      @(posedge clk);
      #1;
      op = 6'b000000;
      push_exp(0, 1'b0, 0);
    end

    run_instr(2, -1, 6'd0);
    run_instr(0, -1, 6'd0);
    run_instr(1, -1, 6'd0);
    run_instr(5, -1, 6'b111111);
    run_instr(3, -1, 6'd0);
    run_instr(4, -1, 6'd0);
    repeat (16) run_instr(4, -1, 6'd0);
    run_instr(2, 5, 6'd0);
    run_instr(4, 5, 6'd0);
    run_instr(5, 4, 6'd0);
    run_instr(3, -1, 6'd0);

    repeat (60) begin
      kind = $urandom_range(0, 5);
      ab = ($urandom_range(0, 7) == 0) ? $urandom_range(1, instr_len(kind) - 1) : -1;
      run_instr(kind, ab, 6'd0);
    end

    @(posedge clk);
    #1;
    reset = 1'b0;
    push_exp(0, m_ill, m_cnt);
    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending entries, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
